quad_encoder_array: RTL and testbench

//  N-channel quadrature encoder front end for the motor subsystem, the parametrised successor to the fixed three-channel encoder inputs.
//  - Per channel: synchronises and deglitches the 2-bit encoder, decodes steps and keeps a wrapping signed position.
//  - Per channel: flags target arrival, counts illegal transitions and measures step period.
//  - A register port is used for configuration and readback.

---
 rtl/quad_encoder_array.sv | 176 +++++++++++++++++
 tb/tb_quad_encoder_array.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_array.sv
// rtl/quad_encoder_array.sv - N-channel quadrature encoder front end with register port
// Optional step-period measurement is built when QENC_PERIOD_EN is defined.
module quad_encoder_array #(
  parameter int NCHAN        = 3,
  parameter int POS_WIDTH    = 32,
  parameter int DGL_CYCLES   = 8,
  parameter int PERIOD_WIDTH = 16,
  parameter int CH_BITS      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2*NCHAN-1:0]   enc,
  input  logic                 we,
  input  logic [CH_BITS+1:0]   wa,
  input  logic [POS_WIDTH-1:0] di,
  input  logic [CH_BITS+1:0]   ra,
  output logic [POS_WIDTH-1:0] rdata,
  output logic [NCHAN-1:0]     reached,
  output logic [NCHAN-1:0]     step
);

  // One readback slot per addressable channel; slots beyond NCHAN read as zero.
  localparam int NSLOT = 2 ** CH_BITS;

  logic [POS_WIDTH-1:0] pos_a  [NSLOT];
  logic [POS_WIDTH-1:0] tgt_a  [NSLOT];
  logic [POS_WIDTH-1:0] stat_a [NSLOT];
  logic [POS_WIDTH-1:0] per_a  [NSLOT];

  logic [CH_BITS-1:0] wa_ch;
  logic [1:0]         wa_reg;
  logic [CH_BITS-1:0] ra_ch;
  logic [1:0]         ra_reg;

  assign wa_ch  = wa[CH_BITS+1:2];
  assign wa_reg = wa[1:0];
  assign ra_ch  = ra[CH_BITS+1:2];
  assign ra_reg = ra[1:0];

  // Gray code to its position in the 00->01->11->10 cycle.
  function automatic logic [1:0] gray_idx(input logic [1:0] c);
    return {c[1], c[1] ^ c[0]};
  endfunction

  for (genvar k = 0; k < NSLOT; k++) begin : g_ch
    if (k < NCHAN) begin : g_live
      logic [1:0]           sync1, sync2, cand, acc, acc_d;
      logic [7:0]           dgl_cnt;
      logic [POS_WIDTH-1:0] pos_q, tgt_q;
      logic [7:0]           err_q;
      logic                 dir_q, reached_q, step_q;
      logic                 wr_sel, pos_wr;
      logic [1:0]           delta;
      logic                 fwd, bwd, bad, took;

      assign wr_sel = we && (wa_ch == CH_BITS'(k));
      assign pos_wr = wr_sel && (wa_reg == 2'd0);
      // acc_d lags acc by one clock, so a nonzero delta marks a freshly accepted code.
      assign delta  = gray_idx(acc) - gray_idx(acc_d);
      assign fwd    = (delta == 2'd1);
      assign bwd    = (delta == 2'd3);
      assign bad    = (delta == 2'd2);
      // A position write wins over a same-cycle step, which is then discarded.
      assign took   = (fwd || bwd) && !pos_wr;

      // Two-flop synchroniser for the asynchronous encoder pins.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1 <= 2'b00;
          sync2 <= 2'b00;
        end else begin
          sync1 <= enc[2*k+1:2*k];
          sync2 <= sync1;
        end
      end

      // Deglitch: a new code must be seen DGL_CYCLES consecutive clocks before acceptance.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cand    <= 2'b00;
          acc     <= 2'b00;
          acc_d   <= 2'b00;
          dgl_cnt <= '0;
        end else begin
          acc_d <= acc;
          if (sync2 == acc) begin
            cand    <= sync2;
            dgl_cnt <= '0;
          end else if (sync2 != cand) begin
            cand    <= sync2;
            dgl_cnt <= 8'd1;
          end else if (dgl_cnt == 8'(DGL_CYCLES - 1)) begin
            acc     <= cand;
            dgl_cnt <= '0;
          end else begin
            dgl_cnt <= dgl_cnt + 8'd1;
          end
        end
      end

      // Decode accepted codes into position, direction, error count and target compare.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pos_q     <= '0;
          tgt_q     <= '0;
          err_q     <= '0;
          dir_q     <= 1'b0;
          step_q    <= 1'b0;
          reached_q <= 1'b0;
        end else begin
          step_q <= 1'b0;
          if (pos_wr) begin
            pos_q <= di;
          end else if (took) begin
            pos_q  <= fwd ? pos_q + POS_WIDTH'(1) : pos_q - POS_WIDTH'(1);
            dir_q  <= fwd;
            step_q <= 1'b1;
          end
          if (wr_sel && (wa_reg == 2'd1)) tgt_q <= di;
          if (wr_sel && (wa_reg == 2'd2)) err_q <= '0;
          else if (bad && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
          reached_q <= (pos_q == tgt_q);
        end
      end

`ifdef QENC_PERIOD_EN
      logic [PERIOD_WIDTH-1:0] pcnt_q, per_q;

      // Period counter: latch and restart on each step, report all-ones once stalled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pcnt_q <= '0;
          per_q  <= '0;
        end else if (took) begin
          per_q  <= pcnt_q;
          pcnt_q <= PERIOD_WIDTH'(1);
        end else if (&pcnt_q) begin
          per_q  <= '1;
        end else begin
          pcnt_q <= pcnt_q + PERIOD_WIDTH'(1);
        end
      end

      assign per_a[k] = POS_WIDTH'(per_q);
`else
      assign per_a[k] = '0;
`endif

      assign pos_a[k]   = pos_q;
      assign tgt_a[k]   = tgt_q;
      assign stat_a[k]  = POS_WIDTH'({dir_q, reached_q, err_q});
      assign step[k]    = step_q;
      assign reached[k] = reached_q;
    end else begin : g_dead
      assign pos_a[k]  = '0;
      assign tgt_a[k]  = '0;
      assign stat_a[k] = '0;
      assign per_a[k]  = '0;
    end
  end

  // Registered readback of the addressed channel register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      case (ra_reg)
        2'd0:    rdata <= pos_a[ra_ch];
        2'd1:    rdata <= tgt_a[ra_ch];
        2'd2:    rdata <= stat_a[ra_ch];
        default: rdata <= per_a[ra_ch];
      endcase
    end
  end

endmodule

// File: tb/tb_quad_encoder_array.sv
// tb/tb_quad_encoder_array.sv - randomized self-checking bench for quad_encoder_array
`timescale 1ns/1ps
module tb_quad_encoder_array;
  localparam int NCHAN = 3;
  localparam int DGL   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  enc = '0;
  logic        we = 1'b0;
  logic [5:0]  wa = '0;
  logic [31:0] di = '0;
  logic [5:0]  ra = '0;
  logic [31:0] rdata;
  logic [2:0]  reached;
  logic [2:0]  step;

  quad_encoder_array #(
    .NCHAN(NCHAN), .POS_WIDTH(32), .DGL_CYCLES(DGL), .PERIOD_WIDTH(16), .CH_BITS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enc(enc), .we(we), .wa(wa), .di(di), .ra(ra),
    .rdata(rdata), .reached(reached), .step(step)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [1:0]  gray [4];
  logic [1:0]  cur  [NCHAN];
  logic [31:0] mpos [NCHAN];
  logic [31:0] mtgt [NCHAN];
  int          merr [NCHAN];
  logic        mdir [NCHAN];
  int          cnt  [NCHAN];
  int          lat  [NCHAN];
  int          rise;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pos_of(input logic [1:0] c);
    for (int i = 0; i < 4; i++) if (gray[i] == c) return i;
    return 0;
  endfunction

  function automatic logic [1:0] nxt(input logic [1:0] c, input int d);
    int idx;
    idx = (pos_of(c) + d + 4) % 4;
    return gray[idx[1:0]];
  endfunction

  function automatic logic [31:0] exp_stat(input int k);
    logic [7:0] e8;
    e8 = 8'(merr[k]);
    return {22'd0, mdir[k], (mpos[k] == mtgt[k]), e8};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCHAN; k++) begin
      cur[k] = 2'b00; mpos[k] = '0; mtgt[k] = '0; merr[k] = 0; mdir[k] = 1'b0;
    end
  endtask

  // Reference: move along the Gray cycle; a jump of two positions is illegal.
  task automatic model_move(input int k, input logic [1:0] c, output int e);
    int d;
    e = 0;
    if (c != cur[k]) begin
      d = (pos_of(c) - pos_of(cur[k]) + 4) % 4;
      cur[k] = c;
      if (d == 1) begin
        mpos[k] = mpos[k] + 32'd1; mdir[k] = 1'b1; e = 1;
      end else if (d == 3) begin
        mpos[k] = mpos[k] - 32'd1; mdir[k] = 1'b0; e = 1;
      end else if (merr[k] < 255) begin
        merr[k]++;
      end
    end
  endtask

  task automatic drive_enc();
    enc = {cur[2], cur[1], cur[0]};
  endtask

  task automatic run(input int n);
    for (int k = 0; k < NCHAN; k++) begin cnt[k] = 0; lat[k] = -1; end
    rise = -1;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NCHAN; k++)
        if (step[k]) begin cnt[k]++; if (lat[k] < 0) lat[k] = i; end
      if (reached[2] && rise < 0) rise = i;
    end
  endtask

  task automatic go(input logic [1:0] c0, input logic [1:0] c1, input logic [1:0] c2, input int n);
    int e [NCHAN];
    model_move(0, c0, e[0]);
    model_move(1, c1, e[1]);
    model_move(2, c2, e[2]);
    drive_enc();
    run(n);
    for (int k = 0; k < NCHAN; k++) check($sformatf("steps_ch%0d", k), cnt[k], e[k]);
  endtask

  task automatic wr(input int ch, input int r, input logic [31:0] d);
    we = 1'b1; wa = {ch[3:0], r[1:0]}; di = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input int ch, input int r, input logic [31:0] exp);
    ra = {ch[3:0], r[1:0]};
    @(posedge clk); #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int gk, g1, e0, e1, e2, c1n, c2n, op;
    logic [1:0] c [NCHAN];
    gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk); #1;
    check("rst_rdata", rdata, 0);
    check("rst_reached", reached, 0);
    check("rst_step", step, 0);
    rst_n = 1'b1;
    run(3);
    check("reached_after_rst", reached, 3'b111);
    chk_rd("pos0_rst", 0, 0, 0);
    chk_rd("stat1_rst", 1, 2, exp_stat(1));

    // Forward cycle on ch0
    go(2'b01, cur[1], cur[2], 20);
    check("lat_ch0", lat[0], DGL + 3);
    go(2'b11, cur[1], cur[2], 20);
    go(2'b10, cur[1], cur[2], 20);
    go(2'b00, cur[1], cur[2], 20);
    chk_rd("t1_pos0", 0, 0, 32'd4);
    chk_rd("t1_stat0", 0, 2, exp_stat(0));

    // Reverse steps and signed wrap
    wr(0, 0, 32'd0); mpos[0] = 32'd0;
    go(2'b10, cur[1], cur[2], 20);
    go(2'b11, cur[1], cur[2], 20);
    go(2'b01, cur[1], cur[2], 20);
    chk_rd("t2_rev", 0, 0, 32'hFFFF_FFFD);
    wr(0, 0, 32'h7FFF_FFFF); mpos[0] = 32'h7FFF_FFFF;
    go(2'b11, cur[1], cur[2], 20);
    chk_rd("t2_wrap", 0, 0, 32'h8000_0000);

    // Glitch rejection, illegal transitions, saturation, clear
    enc[3:2] = 2'b01;
    run(5);
    g1 = cnt[1];
    drive_enc();
    run(20);
    check("t3_glitch", g1 + cnt[1], 0);
    chk_rd("t3_pos1", 1, 0, 0);
    go(cur[0], 2'b11, cur[2], 20);
    chk_rd("t3_err1", 1, 2, exp_stat(1));
    chk_rd("t3_pos1b", 1, 0, 0);
    for (int i = 0; i < 300; i++) go(cur[0], cur[1] ^ 2'b11, cur[2], 12);
    chk_rd("t3_sat", 1, 2, exp_stat(1));
    wr(1, 2, 32'd0); merr[1] = 0;
    chk_rd("t3_clr", 1, 2, exp_stat(1));

    // Target arrival on ch2
    wr(2, 1, 32'd3); mtgt[2] = 32'd3;
    go(cur[0], cur[1], nxt(cur[2], 1), 20);
    go(cur[0], cur[1], nxt(cur[2], 1), 20);
    go(cur[0], cur[1], nxt(cur[2], 1), 20);
    check("t4_lat", lat[2], DGL + 3);
    check("t4_rise", rise, lat[2] + 1);
    check("t4_reached", reached[2], 1'b1);
    go(cur[0], cur[1], nxt(cur[2], 1), 20);
    check("t4_drop", reached[2], 1'b0);

    // Position write colliding with a step
    model_move(0, nxt(cur[0], 1), e0);
    model_move(1, nxt(cur[1], 1), e1);
    model_move(2, nxt(cur[2], 1), e2);
    mpos[0] = 32'd100;
    drive_enc();
    c1n = 0; c2n = 0;
    for (int i = 1; i <= 16; i++) begin
      if (i == DGL + 3) begin we = 1'b1; wa = {4'd0, 2'd0}; di = 32'd100; end
      @(posedge clk); #1;
      we = 1'b0;
      if (step[1]) c1n++;
      if (step[2]) c2n++;
    end
    check("t5_step1", c1n, e1);
    check("t5_step2", c2n, e2);
    chk_rd("t5_pos0", 0, 0, 32'd100);
    chk_rd("t5_pos1", 1, 0, mpos[1]);
    chk_rd("t5_pos2", 2, 0, mpos[2]);

    // Out-of-range channels
    wr(5, 0, 32'h1234);
    chk_rd("ch5_pos", 5, 0, 0);
    chk_rd("ch3_tgt", 3, 1, 0);

    // Randomized steps, reversals, illegal jumps and glitches on all channels
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        gk = $urandom_range(0, 2);
        enc[2*gk +: 2] = cur[gk] ^ 2'b01;
        run($urandom_range(1, DGL - 3));
        g1 = cnt[gk];
        drive_enc();
        run(DGL + 4);
        check($sformatf("rnd_glitch_ch%0d", gk), g1 + cnt[gk], 0);
      end
      for (int k = 0; k < NCHAN; k++) begin
        op = $urandom_range(0, 3);
        case (op)
          0: c[k] = cur[k];
          1: c[k] = nxt(cur[k], 1);
          2: c[k] = nxt(cur[k], -1);
          default: c[k] = cur[k] ^ 2'b11;
        endcase
      end
      go(c[0], c[1], c[2], 14);
    end
    for (int k = 0; k < NCHAN; k++) begin
      chk_rd($sformatf("rnd_pos%0d", k), k, 0, mpos[k]);
      chk_rd($sformatf("rnd_tgt%0d", k), k, 1, mtgt[k]);
      chk_rd($sformatf("rnd_stat%0d", k), k, 2, exp_stat(k));
    end

`ifdef QENC_PERIOD_EN
    // Step period on ch2, then stall
    for (int i = 0; i < 4; i++) go(cur[0], cur[1], nxt(cur[2], 1), 50);
    chk_rd("per_50", 2, 3, 32'd50);
    run(65400);
    chk_rd("per_hold", 2, 3, 32'd50);
    run(200);
    chk_rd("per_stall", 2, 3, 32'h0000_FFFF);
`else
    for (int k = 0; k < NCHAN; k++) chk_rd($sformatf("per_off%0d", k), k, 3, 0);
`endif

    // Asynchronous reset mid-operation; first code decoded against 00
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_step", step, 0);
    check("mid_rst_reached", reached, 0);
    check("mid_rst_rdata", rdata, 0);
    model_reset();
    enc = 6'b00_01_11;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_move(0, 2'b11, e0);
    model_move(1, 2'b01, e1);
    drive_enc();
    run(16);
    check("post_rst_step0", cnt[0], e0);
    check("post_rst_step1", cnt[1], e1);
    chk_rd("post_rst_stat0", 0, 2, exp_stat(0));
    chk_rd("post_rst_pos1", 1, 0, mpos[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
